// File: rtl/asignador_cubos.sv
// asignador_cubos: receives spawn requests and places each cube into the
// lowest-index free slot of five. Every pulso_caida moves all falling cubes
// down by PASO_Y. A cube is released when its next Y would reach Y_LIMITE.
// Optional feature: define CONTADOR_CAIDOS_EN to make cubos_caidos a
// saturating count of released cubes. When it is undefined, cubos_caidos is 0.
module asignador_cubos #(
  parameter int PASO_Y    = 4,
  parameter int Y_LIMITE  = 480,
  parameter int Y_INICIAL = 0,
  parameter int X_LIBRE   = 511
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       pulso_habilitar,
  input  logic [8:0] pos_seleccionada,
  input  logic       pulso_caida,
  output logic [8:0] pos_x_c1,
  output logic [8:0] pos_x_c2,
  output logic [8:0] pos_x_c3,
  output logic [8:0] pos_x_c4,
  output logic [8:0] pos_x_c5,
  output logic [9:0] pos_y_c1,
  output logic [9:0] pos_y_c2,
  output logic [9:0] pos_y_c3,
  output logic [9:0] pos_y_c4,
  output logic [9:0] pos_y_c5,
  output logic [4:0] activo,
  output logic       lleno,
  output logic       pulso_descartado,
  output logic       pulso_fin_cubo,
  output logic [7:0] cubos_caidos
);

  localparam int          NUM_SLOTS = 5;
  localparam logic [10:0] PASO_W    = 11'(PASO_Y);
  localparam logic [10:0] LIMITE_W  = 11'(Y_LIMITE);
  localparam logic [9:0]  Y_INI_W   = 10'(Y_INICIAL);
  localparam logic [8:0]  X_LIBRE_W = 9'(X_LIBRE);

  // Per-slot registered state. The activo bit is the LIBRE/CAYENDO state.
  logic [8:0] pos_x_q [NUM_SLOTS];
  logic [8:0] pos_x_d [NUM_SLOTS];
  logic [9:0] pos_y_q [NUM_SLOTS];
  logic [9:0] pos_y_d [NUM_SLOTS];
  logic [4:0] activo_q, activo_d;
  logic       descartado_q, descartado_d;
  logic       fin_cubo_q, fin_cubo_d;

  logic [4:0] libre_oh;   // one-hot: lowest free slot before this edge
  logic [4:0] liberado;   // slots released on this edge

  assign lleno = &activo_q;

  // Find the lowest-index free slot, using the state from before this edge.
  always_comb begin
    // NOTE: every variable assigned in always_comb gets a default first.
    // Otherwise a path that does not assign it would infer a latch.
    logic found;
    found    = 1'b0;
    libre_oh = '0;
    for (int i = 0; i < NUM_SLOTS; i++) begin
      if (!activo_q[i] && !found) begin
        libre_oh[i] = 1'b1;
        found       = 1'b1;
      end
    end
  end

  // Next state: fall and release first, then allocation into a pre-edge free slot.
  always_comb begin
    logic [10:0] suma;
    suma         = '0;
    pos_x_d      = pos_x_q;
    pos_y_d      = pos_y_q;
    activo_d     = activo_q;
    liberado     = '0;
    descartado_d = pulso_habilitar && lleno;
    for (int i = 0; i < NUM_SLOTS; i++) begin
      // An 11-bit sum cannot wrap, so the bottom compare is always correct.
      suma = {1'b0, pos_y_q[i]} + PASO_W;
      if (pulso_caida && activo_q[i]) begin
        if (suma >= LIMITE_W) begin
          activo_d[i] = 1'b0;
          pos_x_d[i]  = X_LIBRE_W;
          pos_y_d[i]  = '0;
          liberado[i] = 1'b1;
        end else begin
          pos_y_d[i] = suma[9:0];
        end
      end
      // The target slot was free before the edge, so the fall above never
      // touched it. A slot released on this edge cannot be chosen here.
      if (pulso_habilitar && !lleno && libre_oh[i]) begin
        activo_d[i] = 1'b1;
        pos_x_d[i]  = pos_seleccionada;
        pos_y_d[i]  = Y_INI_W;
      end
    end
    fin_cubo_d = |liberado;
  end

  // Slot and pulse registers, cleared by synchronous reset.
  always_ff @(posedge clk) begin
    // NOTE: the slot arrays are reset as well. They are only five entries
    // and drive outputs directly, so the reset values must be visible.
    if (reset) begin
      for (int i = 0; i < NUM_SLOTS; i++) begin
        // NOTE: sequential state uses non-blocking assignments, so every
        // flop samples its pre-edge inputs.
        pos_x_q[i] <= X_LIBRE_W;
        pos_y_q[i] <= '0;
      end
      activo_q     <= '0;
      descartado_q <= 1'b0;
      fin_cubo_q   <= 1'b0;
    end else begin
      pos_x_q      <= pos_x_d;
      pos_y_q      <= pos_y_d;
      activo_q     <= activo_d;
      descartado_q <= descartado_d;
      fin_cubo_q   <= fin_cubo_d;
    end
  end

`ifdef CONTADOR_CAIDOS_EN
  logic [7:0] cubos_caidos_q, cubos_caidos_d;

  // Add this edge's releases (0..5) and hold the result at 255.
  always_comb begin
    logic [8:0] suma_caidos;
    suma_caidos = {1'b0, cubos_caidos_q};
    for (int i = 0; i < NUM_SLOTS; i++) begin
      suma_caidos = suma_caidos + {8'd0, liberado[i]};
    end
    cubos_caidos_d = suma_caidos[8] ? 8'hFF : suma_caidos[7:0];
  end

  // Released-cube counter register. Only reset clears it.
  always_ff @(posedge clk) begin
    if (reset) cubos_caidos_q <= '0;
    else       cubos_caidos_q <= cubos_caidos_d;
  end

  assign cubos_caidos = cubos_caidos_q;
`else
  assign cubos_caidos = 8'd0;
`endif

  assign pos_x_c1 = pos_x_q[0];
  assign pos_x_c2 = pos_x_q[1];
  assign pos_x_c3 = pos_x_q[2];
  assign pos_x_c4 = pos_x_q[3];
  assign pos_x_c5 = pos_x_q[4];
  assign pos_y_c1 = pos_y_q[0];
  assign pos_y_c2 = pos_y_q[1];
  assign pos_y_c3 = pos_y_q[2];
  assign pos_y_c4 = pos_y_q[3];
  assign pos_y_c5 = pos_y_q[4];
  assign activo           = activo_q;
  assign pulso_descartado = descartado_q;
  assign pulso_fin_cubo   = fin_cubo_q;

endmodule

// File: tb/tb_asignador_cubos.sv
// Self-checking bench for asignador_cubos. A behavioural model predicts
// the outputs for each driven cycle and pushes them to a scoreboard queue.
// They are popped and compared just after the clock edge.
module tb_asignador_cubos;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       pulso_habilitar = 1'b0;
  logic [8:0] pos_seleccionada = '0;
  logic       pulso_caida = 1'b0;
  logic [8:0] pos_x_c1, pos_x_c2, pos_x_c3, pos_x_c4, pos_x_c5;
  logic [9:0] pos_y_c1, pos_y_c2, pos_y_c3, pos_y_c4, pos_y_c5;
  logic [4:0] activo;
  logic       lleno, pulso_descartado, pulso_fin_cubo;
  logic [7:0] cubos_caidos;

  asignador_cubos dut (
    .clk(clk), .reset(reset),
    .pulso_habilitar(pulso_habilitar), .pos_seleccionada(pos_seleccionada),
    .pulso_caida(pulso_caida),
    .pos_x_c1(pos_x_c1), .pos_x_c2(pos_x_c2), .pos_x_c3(pos_x_c3),
    .pos_x_c4(pos_x_c4), .pos_x_c5(pos_x_c5),
    .pos_y_c1(pos_y_c1), .pos_y_c2(pos_y_c2), .pos_y_c3(pos_y_c3),
    .pos_y_c4(pos_y_c4), .pos_y_c5(pos_y_c5),
    .activo(activo), .lleno(lleno), .pulso_descartado(pulso_descartado),
    .pulso_fin_cubo(pulso_fin_cubo), .cubos_caidos(cubos_caidos)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [44:0] x;
    logic [49:0] y;
    logic [4:0]  act;
    logic        desc;
    logic        fin;
    logic [7:0]  caidos;
  } exp_t;

  exp_t       sb[$];
  int         n_checks = 0;
  int         n_pass   = 0;

  // Model state
  logic [8:0] m_x [5];
  logic [9:0] m_y [5];
  logic [4:0] m_act;
  logic       m_desc, m_fin;
  int         m_caidos;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
  endtask

  // Drive one cycle, predict its result, then compare it after the edge.
  task automatic step(input logic rst, input logic hab, input logic [8:0] pos, input logic caida);
    exp_t e;
    logic full;
    int   free, nrel;
    reset            = rst;
    pulso_habilitar  = hab;
    pos_seleccionada = pos;
    pulso_caida      = caida;
    if (rst) begin
      for (int i = 0; i < 5; i++) begin m_x[i] = 9'd511; m_y[i] = '0; end
      m_act = '0; m_desc = 1'b0; m_fin = 1'b0; m_caidos = 0;
    end else begin
      full = (m_act == 5'b11111);
      free = -1;
      for (int i = 0; i < 5; i++) if (!m_act[i] && free < 0) free = i;
      nrel = 0;
      if (caida) begin
        for (int i = 0; i < 5; i++) begin
          if (m_act[i]) begin
            if (int'(m_y[i]) + 4 >= 480) begin
              m_act[i] = 1'b0; m_x[i] = 9'd511; m_y[i] = '0; nrel++;
            end else m_y[i] = m_y[i] + 10'd4;
          end
        end
      end
      m_desc = hab && full;
      if (hab && !full) begin
        m_act[free] = 1'b1; m_x[free] = pos; m_y[free] = '0;
      end
      m_fin = (nrel > 0);
`ifdef CONTADOR_CAIDOS_EN
      m_caidos = (m_caidos + nrel > 255) ? 255 : m_caidos + nrel;
`endif
    end
    e.x      = {m_x[4], m_x[3], m_x[2], m_x[1], m_x[0]};
    e.y      = {m_y[4], m_y[3], m_y[2], m_y[1], m_y[0]};
    e.act    = m_act;
    e.desc   = m_desc;
    e.fin    = m_fin;
    e.caidos = 8'(m_caidos);
    sb.push_back(e);
    @(posedge clk);
    #1;
    e = sb.pop_front();
    check("pos_x", 64'({pos_x_c5, pos_x_c4, pos_x_c3, pos_x_c2, pos_x_c1}), 64'(e.x));
    check("pos_y", 64'({pos_y_c5, pos_y_c4, pos_y_c3, pos_y_c2, pos_y_c1}), 64'(e.y));
    check("activo", 64'(activo), 64'(e.act));
    check("lleno", 64'(lleno), 64'(e.act == 5'b11111));
    check("descartado", 64'(pulso_descartado), 64'(e.desc));
    check("fin_cubo", 64'(pulso_fin_cubo), 64'(e.fin));
    check("caidos", 64'(cubos_caidos), 64'(e.caidos));
  endtask

  task automatic ticks(input int n);
    for (int k = 0; k < n; k++) step(1'b0, 1'b0, 9'd0, 1'b1);
  endtask

  task automatic alloc(input logic [8:0] x);
    step(1'b0, 1'b1, x, 1'b0);
  endtask

  task automatic do_reset();
    step(1'b1, 1'b0, 9'd0, 1'b0);
  endtask

  initial begin
    // Reset values
    do_reset();
    do_reset();
    check("rst_activo", 64'(activo), 64'd0);
    check("rst_x5", 64'(pos_x_c5), 64'd511);

    // Single allocation
    alloc(9'd100);
    check("a1_activo", 64'(activo), 64'b00001);
    check("a1_x1", 64'(pos_x_c1), 64'd100);
    check("a1_x2", 64'(pos_x_c2), 64'd511);
    step(1'b0, 1'b0, 9'd0, 1'b0);

    // Fill all five slots, then a request while full
    do_reset();
    for (int i = 1; i <= 5; i++) alloc(9'(10 * i));
    check("full_lleno", 64'(lleno), 64'd1);
    alloc(9'd60);
    check("full_desc", 64'(pulso_descartado), 64'd1);
    check("full_x5", 64'(pos_x_c5), 64'd50);
    step(1'b0, 1'b0, 9'd0, 1'b0);
    check("full_desc_1cyc", 64'(pulso_descartado), 64'd0);

    // One cube falling to the bottom
    do_reset();
    alloc(9'd77);
    ticks(119);
    check("fall_y476", 64'(pos_y_c1), 64'd476);
    ticks(1);
    check("fall_rel_act", 64'(activo), 64'd0);
    check("fall_rel_x", 64'(pos_x_c1), 64'd511);
    check("fall_fin", 64'(pulso_fin_cubo), 64'd1);
    step(1'b0, 1'b0, 9'd0, 1'b0);
    check("fall_fin_1cyc", 64'(pulso_fin_cubo), 64'd0);

    // Full, slot 2 at 476, request and tick together -> discard
    do_reset();
    alloc(9'd1);
    ticks(60);
    alloc(9'd2);
    ticks(60);
    for (int i = 0; i < 4; i++) alloc(9'(3 + i));
    ticks(59);
    check("sim_y2", 64'(pos_y_c2), 64'd476);
    step(1'b0, 1'b1, 9'd200, 1'b1);
    check("sim_desc", 64'(pulso_descartado), 64'd1);
    check("sim_act", 64'(activo), 64'b11101);
    alloc(9'd200);
    check("sim_x2", 64'(pos_x_c2), 64'd200);
    check("sim_y2_new", 64'(pos_y_c2), 64'd0);

    // Slots 1 and 3 active, slot 2 free, request and tick together
    do_reset();
    alloc(9'd11);
    alloc(9'd12);
    ticks(60);
    alloc(9'd13);
    ticks(60);
    alloc(9'd21);
    step(1'b0, 1'b1, 9'd300, 1'b1);
    check("mix_x2", 64'(pos_x_c2), 64'd300);
    check("mix_y2", 64'(pos_y_c2), 64'd0);
    check("mix_y1", 64'(pos_y_c1), 64'd4);
    check("mix_y3", 64'(pos_y_c3), 64'd244);

    // Reset mid-fall, with pulses in the same cycle ignored
    do_reset();
    for (int i = 0; i < 3; i++) alloc(9'(40 + i));
    ticks(5);
    step(1'b1, 1'b1, 9'd99, 1'b1);
    check("mrst_act", 64'(activo), 64'd0);
    check("mrst_y1", 64'(pos_y_c1), 64'd0);

    // 300 released cubes, to reach counter saturation
    do_reset();
    for (int r = 0; r < 60; r++) begin
      for (int i = 0; i < 5; i++) alloc(9'($urandom_range(0, 400)));
      ticks(120);
    end
`ifdef CONTADOR_CAIDOS_EN
    check("caidos_sat", 64'(cubos_caidos), 64'd255);
`else
    check("caidos_off", 64'(cubos_caidos), 64'd0);
`endif

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/asignador_cubos.md
Name: asignador_cubos

Overview:
- Receiving end of the position-selection handshake. Consumes the one-cycle enable pulse and the selected X position from the spawn controller.
- Places each new cube into the lowest-index free slot of 5 and drives its fall on the time tick.
- Releases a slot when its cube reaches the bottom.
- Drives the per-slot X positions back to the spawn controller, so collision checks always reflect the live cubes.

Parameters:
- PASO_Y, 4, pixels added to Y of every active cube per pulso_caida.
- Y_LIMITE, 480, bottom row; a cube whose next Y is >= Y_LIMITE is released instead of moved.
- Y_INICIAL, 0, Y loaded on allocation.
- X_LIBRE, 511, X value driven for an inactive slot; never a legal spawn position, so it never matches in collision compares.

Ports:
- clk  input  1  system clock, all logic on rising edge
- reset  input  1  synchronous, active-high
- pulso_habilitar  input  1  one-cycle request: place a cube at pos_seleccionada
- pos_seleccionada  input  9  X of the requested cube, valid when pulso_habilitar=1
- pulso_caida  input  1  one-cycle fall tick
- pos_x_c1..pos_x_c5  output  9 each  X of slot 1..5 (X_LIBRE when inactive)
- pos_y_c1..pos_y_c5  output  10 each  Y of slot 1..5 (0 when inactive)
- activo  output  5  bit i-1 = slot i holds a cube
- lleno  output  1  combinational, =1 when activo==5'b11111
- pulso_descartado  output  1  one-cycle, request arrived while lleno
- pulso_fin_cubo  output  1  one-cycle, at least one cube released this tick
- cubos_caidos  output  8  see Optional Feature

Behaviour:
- Reset state (synchronous): activo=0, all pos_x=X_LIBRE, all pos_y=0, pulso_descartado=0, pulso_fin_cubo=0, cubos_caidos=0.
- Reset asserted mid-operation: all slots cleared on that edge. Any pulse in the same cycle is ignored.
- Per-slot state: 2 states, LIBRE and CAYENDO, encoded by the activo bit. X and Y are registered per slot.
- Allocation (pulso_habilitar=1, lleno=0):
  - Target is the lowest-index slot with activo=0, judged on the registered state at the start of the cycle.
  - Next edge: pos_x = pos_seleccionada, pos_y = Y_INICIAL, activo bit set.
  - Latency is 1 cycle: new X is visible on pos_x_cN the cycle after the pulse.
- Request while full (pulso_habilitar=1, lleno=1): no slot changes. pulso_descartado=1 for exactly the next cycle.
- Fall (pulso_caida=1): for each slot already CAYENDO at the start of the cycle:
  - Compute suma = pos_y + PASO_Y in 11 bits, so there is no wrap.
  - If suma >= Y_LIMITE: slot -> LIBRE, pos_x = X_LIBRE, pos_y = 0.
  - Else: pos_y = suma.
  - If one or more slots are released, pulso_fin_cubo=1 for the next cycle.
- Simultaneous pulso_habilitar and pulso_caida:
  - The newly allocated slot is not moved on that tick; it starts at Y_INICIAL.
  - A slot released on that tick is not eligible for the same-cycle allocation. Free-slot search uses pre-edge state.
  - If all slots were full pre-edge, the request is discarded even if a release occurs.
- pulso_habilitar held high for multiple cycles is treated as repeated requests, one per cycle.
- No arithmetic on X; it is stored as received.

Optional Feature:
- Macro: CONTADOR_CAIDOS_EN.
- Defined: cubos_caidos is an 8-bit saturating counter.
  - Adds the number of slots released per pulso_caida (0..5) in one edge.
  - Holds at 255.
  - Cleared only by reset.
- Undefined: cubos_caidos tied to 8'd0. Port still present; no counter logic.

Test Plan:
- Reset, then pulso_habilitar with pos_seleccionada=100 -> next cycle activo=5'b00001, pos_x_c1=100, pos_y_c1=0; pos_x_c2..c5=511.
- Five requests at X=10,20,30,40,50 in consecutive cycles, then a sixth at 60 -> slots 1..5 hold 10..50, lleno=1, pulso_descartado=1 one cycle, no slot modified.
- One cube, 119 pulso_caida ticks -> pos_y_c1=476. Tick 120 (476+4=480 >= 480) -> activo bit0=0, pos_x_c1=511, pos_y_c1=0, pulso_fin_cubo=1 one cycle.
- Slots 1..5 full, slot 2 at Y=476, pulso_habilitar (X=200) and pulso_caida in same cycle -> slot 2 released, request discarded (pulso_descartado=1). The next request lands in slot 2 with X=200, Y=0.
- Cubes in slots 1 and 3, slot 2 free, simultaneous request X=300 and tick -> slot 2 gets X=300, Y=0. Slots 1 and 3 advance by 4.
- Reset mid-fall with 3 active cubes -> all outputs at reset values next cycle.
- With CONTADOR_CAIDOS_EN: 300 released cubes -> cubos_caidos=255. Without the macro -> cubos_caidos stays 0.
